muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int MULDIV_XLEN  = 32;
  localparam int MULDIV_ITERS = MULDIV_XLEN;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} pair: shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shl;
  logic [XLEN:0] w_diff;

  // Extra top bit keeps the add carry and the trial-subtract borrow.
  assign w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
  assign w_shl  = {i_hi, i_lo[XLEN-1]};
  assign w_diff = w_shl - {1'b0, i_opnd};

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    if (i_is_div) begin
      o_hi = w_diff[XLEN] ? w_shl[XLEN-1:0] : w_diff[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], ~w_diff[XLEN]};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: XLEN CALC iterations plus a FIX cycle for sign
// correction; divide-by-zero and signed overflow complete straight from accept.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic            Kill,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_e     r_state, w_state_nxt;
  muldiv_op_e        r_op, w_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo, r_opnd, r_result;
  logic              r_neg_res, r_neg_rem;

  logic              w_accept, w_a_signed, w_b_signed, w_sa, w_sb;
  logic              w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_res;
  logic [XLEN-1:0]   w_step_hi, w_step_lo, w_quo, w_rem, w_fix_res;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  assign w_op     = muldiv_op_e'(Funct3);
  assign w_accept = Start && !Kill && (r_state == ST_IDLE || r_state == ST_DONE);

  assign w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_sa       = w_a_signed & SrcA[XLEN-1];
  assign w_sb       = w_b_signed & SrcB[XLEN-1];
  assign w_mag_a    = w_sa ? -SrcA : SrcA;
  assign w_mag_b    = w_sb ? -SrcB : SrcB;

  assign w_div0    = is_div(w_op) && (SrcB == '0);
  assign w_ovf     = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                     (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
  assign w_special = w_div0 || w_ovf;
  // Funct3[1] separates remainder ops from quotient ops within the divide group.
  assign w_special_res = w_div0 ? (w_op[1] ? SrcA : '1)
                                : (w_op[1] ? '0 : SrcA);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (is_div(r_op)),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_opnd   (r_opnd),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quo      = r_neg_res ? -r_lo : r_lo;
  assign w_rem      = r_neg_rem ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = '0;
    unique case (r_op)
      OP_MUL:                      w_fix_res = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_fix_res = w_quo;
      default:                     w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_state_nxt = w_special ? ST_DONE : ST_CALC;
        else          w_state_nxt = ST_IDLE;
      end
      ST_CALC: begin
        if (Kill)              w_state_nxt = ST_IDLE;
        else if (r_cnt == '0)  w_state_nxt = ST_FIX;
      end
      default: w_state_nxt = Kill ? ST_IDLE : ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_MUL;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_result  <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_cnt     <= CNT_W'(XLEN-1);
      r_hi      <= '0;
      r_neg_res <= w_sa ^ w_sb;
      r_neg_rem <= w_sa;
      // lo holds the multiplier for multiply, the dividend for divide.
      r_opnd    <= is_div(w_op) ? w_mag_b : w_mag_a;
      r_lo      <= is_div(w_op) ? w_mag_a : w_mag_b;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == ST_CALC) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (r_state == ST_FIX && !Kill) begin
      r_result <= w_fix_res;
    end
  end

  assign Busy   = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign Done   = (r_state == ST_DONE);
  assign Result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: results, latency, Busy span, kill and reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, Start, Kill;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [31:0] Result;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'h0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Kill   (Kill),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns 1 ns after the accept edge with inputs scrambled.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit push);
    Funct3 = f;
    SrcA   = a;
    SrcB   = b;
    Start  = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    Start  = 1'b0;
    Funct3 = ~f;
    SrcA   = $urandom;
    SrcB   = $urandom;
  endtask

  // Latency counts edges from the accept edge to the edge that samples Done=1.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy, input int poke);
    int          lat  = 0;
    int          busy = 0;
    bit          seen = 1'b0;
    logic [31:0] exp;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(negedge clk);
      if (poke != 0 && i == poke) begin
        Start  = 1'b1;
        Funct3 = 3'b000;
        SrcA   = 32'h5;
        SrcB   = 32'h5;
      end
      if (poke != 0 && i == poke + 1) Start = 1'b0;
      if (Busy) busy++;
      if (Done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_cycles"}, busy, exp_busy);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    chk({tag, " result"}, Result, exp);
    last_res = exp;
  endtask

  task automatic pulse_check(input string tag);
    @(negedge clk);
    chk({tag, " done_single"}, 32'(Done), 32'd0);
    chk({tag, " result_hold"}, Result, last_res);
  endtask

  initial begin
    int dcnt;
    reset  = 1'b1;
    Start  = 1'b0;
    Kill   = 1'b0;
    Funct3 = 3'b000;
    SrcA   = 32'h0;
    SrcB   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset done", 32'(Done), 32'd0);
    chk("reset result", Result, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    wait_done("mul", 34, 33, 0);
    pulse_check("mul");

    start_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    wait_done("mulh", 34, 33, 0);
    pulse_check("mulh");

    start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    wait_done("mulhu", 34, 33, 0);
    pulse_check("mulhu");

    start_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("mulhsu", 34, 33, 0);
    pulse_check("mulhsu");

    // Back-to-back: the next Start is issued in the Done cycle.
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    wait_done("div", 34, 33, 0);
    start_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    wait_done("rem_b2b", 34, 33, 0);
    start_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b1);
    wait_done("divu_b2b", 34, 33, 0);
    start_op(OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 1'b1);
    wait_done("remu_b2b", 34, 33, 0);
    pulse_check("remu");

    start_op(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wait_done("div0", 1, 0, 0);
    pulse_check("div0");
    start_op(OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
    wait_done("remu0", 1, 0, 0);
    pulse_check("remu0");
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    wait_done("div_ovf", 1, 0, 0);
    start_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    wait_done("rem_ovf", 1, 0, 0);
    pulse_check("rem_ovf");

    start_op(OP_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b1);
    wait_done("start_while_busy", 34, 33, 5);
    pulse_check("start_while_busy");

    // Start together with Kill must not launch anything.
    Kill   = 1'b1;
    Start  = 1'b1;
    Funct3 = OP_MUL;
    SrcA   = 32'd9;
    SrcB   = 32'd9;
    @(negedge clk);
    Start = 1'b0;
    Kill  = 1'b0;
    chk("start_kill busy", 32'(Busy), 32'd0);

    start_op(OP_MUL, 32'd3, 32'd5, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    Kill = 1'b1;
    @(negedge clk);
    Kill = 1'b0;
    chk("kill busy", 32'(Busy), 32'd0);
    chk("kill done", 32'(Done), 32'd0);
    chk("kill result", Result, last_res);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) dcnt++;
    end
    chk("kill no_done", dcnt, 0);

    start_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_done("divu_after_kill", 34, 33, 0);
    pulse_check("divu_after_kill");

    start_op(OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 32'd0, 1'b0);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset busy", 32'(Busy), 32'd0);
    chk("midreset done", 32'(Done), 32'd0);
    chk("midreset result", Result, 32'h0);
    reset    = 1'b0;
    last_res = 32'h0;
    start_op(OP_MUL, 32'd3, 32'd4, 32'd12, 1'b1);
    wait_done("mul_after_reset", 34, 33, 0);
    pulse_check("mul_after_reset");

    chk("scoreboard empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
